// File: rtl/mips_muldiv_unit.sv
//------------------------------------------------------------------------------
// mips_muldiv_unit : iterative MULT/MULTU/DIV/DIVU engine with HI/LO registers.
// Optional feature macro: MULDIV_EARLY_OUT_EN (multiply terminates once the
// remaining multiplier bits are zero).
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module mips_muldiv_unit #(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = $clog2(DATA_WIDTH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_start,
    input  logic [1:0]            i_op,
    input  logic                  i_flush,
    input  logic [DATA_WIDTH-1:0] i_rs_data,
    input  logic [DATA_WIDTH-1:0] i_rt_data,
    output logic                  o_busy,
    output logic                  o_done,
    output logic [DATA_WIDTH-1:0] o_hi,
    output logic [DATA_WIDTH-1:0] o_lo,
    output logic                  o_div_by_zero
);
    localparam int W = DATA_WIDTH;
    localparam logic [CNT_WIDTH-1:0] c_LAST_CNT = CNT_WIDTH'(W - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_PREP = 2'd1,
        S_RUN  = 2'd2,
        S_FIX  = 2'd3
    } state_t;

    state_t               r_state;
    state_t               w_next_state;
    logic [1:0]           r_op;
    logic [W-1:0]         r_a;
    logic [W-1:0]         r_b;
    logic [2*W-1:0]       r_mcand;
    logic [2*W-1:0]       r_acc;
    logic [CNT_WIDTH-1:0] r_cnt;
    logic                 r_neg_q;
    logic                 r_neg_r;
    logic                 r_dz_pend;
    logic [W-1:0]         r_hi;
    logic [W-1:0]         r_lo;
    logic                 r_dz;
    logic                 r_done;

    logic                 w_launch;
    logic                 w_in_dz;
    logic                 w_is_div;
    logic                 w_signed;
    logic                 w_a_neg;
    logic                 w_b_neg;
    logic [W-1:0]         w_a_abs;
    logic [W-1:0]         w_b_abs;
    logic [2*W-1:0]       w_mul_acc;
    logic [W:0]           w_rem_sh;
    logic [W:0]           w_diff;
    logic [2*W-1:0]       w_div_acc;
    logic                 w_run_last;
    logic [2*W-1:0]       w_prod;
    logic [W-1:0]         w_fix_hi;
    logic [W-1:0]         w_fix_lo;

    assign w_launch = (r_state == S_IDLE) && i_start && !i_flush;
    assign w_in_dz  = i_op[1] && (i_rt_data == '0);
    assign w_is_div = r_op[1];
    assign w_signed = ~r_op[0];

    assign w_a_neg = w_signed & r_a[W-1];
    assign w_b_neg = w_signed & r_b[W-1];
    assign w_a_abs = w_a_neg ? -r_a : r_a;
    assign w_b_abs = w_b_neg ? -r_b : r_b;

    // Multiply: multiplier LSB-first, multiplicand shifted left each step.
    assign w_mul_acc = r_b[0] ? (r_acc + r_mcand) : r_acc;

    // Restoring divide on {remainder, quotient}; the subtraction borrow picks the quotient bit.
    assign w_rem_sh  = r_acc[2*W-1:W-1];
    assign w_diff    = w_rem_sh - {1'b0, r_b};
    assign w_div_acc = w_diff[W] ? {w_rem_sh[W-1:0], r_acc[W-2:0], 1'b0}
                                 : {w_diff[W-1:0],   r_acc[W-2:0], 1'b1};

`ifdef MULDIV_EARLY_OUT_EN
    assign w_run_last = (r_cnt == c_LAST_CNT) || (!w_is_div && (r_b[W-1:1] == '0));
`else
    assign w_run_last = (r_cnt == c_LAST_CNT);
`endif

    // Divide-by-zero presets leave both sign flags clear, so the raw preset passes through.
    assign w_prod = r_neg_q ? -r_acc : r_acc;
    always_comb begin
        w_fix_hi = w_prod[2*W-1:W];
        w_fix_lo = w_prod[W-1:0];
        if (w_is_div) begin
            w_fix_hi = r_neg_r ? -r_acc[2*W-1:W] : r_acc[2*W-1:W];
            w_fix_lo = r_neg_q ? -r_acc[W-1:0]   : r_acc[W-1:0];
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:  if (w_launch) w_next_state = w_in_dz ? S_FIX : S_PREP;
            S_PREP:  w_next_state = S_RUN;
            S_RUN:   if (w_run_last) w_next_state = S_FIX;
            S_FIX:   w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
        if (i_flush) begin
            w_next_state = S_IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op      <= '0;
            r_a       <= '0;
            r_b       <= '0;
            r_mcand   <= '0;
            r_acc     <= '0;
            r_cnt     <= '0;
            r_neg_q   <= 1'b0;
            r_neg_r   <= 1'b0;
            r_dz_pend <= 1'b0;
            r_hi      <= '0;
            r_lo      <= '0;
            r_dz      <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_launch) begin
                        r_op      <= i_op;
                        r_a       <= i_rs_data;
                        r_b       <= i_rt_data;
                        r_neg_q   <= 1'b0;
                        r_neg_r   <= 1'b0;
                        r_dz_pend <= w_in_dz;
                        r_acc     <= {i_rs_data, {W{1'b1}}};
                    end
                end
                S_PREP: begin
                    r_a     <= w_a_abs;
                    r_b     <= w_b_abs;
                    r_neg_q <= w_a_neg ^ w_b_neg;
                    r_neg_r <= w_a_neg;
                    r_mcand <= {{W{1'b0}}, w_a_abs};
                    r_acc   <= w_is_div ? {{W{1'b0}}, w_a_abs} : '0;
                    r_cnt   <= '0;
                end
                S_RUN: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (w_is_div) begin
                        r_acc <= w_div_acc;
                    end else begin
                        r_acc   <= w_mul_acc;
                        r_mcand <= r_mcand << 1;
                        r_b     <= r_b >> 1;
                    end
                end
                S_FIX: begin
                    if (!i_flush) begin
                        r_hi   <= w_fix_hi;
                        r_lo   <= w_fix_lo;
                        r_dz   <= r_dz_pend;
                        r_done <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_busy        = (r_state != S_IDLE);
    assign o_done        = r_done;
    assign o_hi          = r_hi;
    assign o_lo          = r_lo;
    assign o_div_by_zero = r_dz;

endmodule

`default_nettype wire

// File: doc/mips_muldiv_unit.md
# mips_muldiv_unit

Iterative multiply/divide unit with architectural HI/LO registers for the pipelined MIPS core. It is parametrised in operand width and executes MULT, MULTU, DIV and DIVU as a multicycle operation alongside the EX stage. A busy/done handshake lets the hazard logic stall dependent MFHI/MFLO instructions until the result is ready.

## Interface
Parameters:
- DATA_WIDTH, 32, operand/HI/LO width W (even, ≥4)
- CNT_WIDTH, $clog2(DATA_WIDTH), iteration counter width

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low; clears all state
- start  in  1  launch request, sampled on rising edge
- op  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU
- flush  in  1  abort in-flight operation (pipeline kill)
- rs_data  in  W  operand A (multiplicand / dividend)
- rt_data  in  W  operand B (multiplier / divisor)
- busy  out  1  high while an operation is in flight
- done  out  1  one-cycle pulse, HI/LO updated this cycle
- hi  out  W  HI register (product upper half / remainder)
- lo  out  W  LO register (product lower half / quotient)
- div_by_zero  out  1  last completed op was DIV/DIVU with B=0

## Operation
- Reset values: busy=0, done=0, hi=0, lo=0, div_by_zero=0, state IDLE.
- States: IDLE, PREP, RUN, FIX.
- IDLE: start=1 and flush=0 → capture op/operands, go to PREP. Exception: DIV/DIVU with rt_data=0 goes straight to FIX with result preset to HI=rs_data, LO=all ones, dz=1.
- PREP: for signed ops, take absolute values and record the result sign(s); clear the accumulator; count=0 → RUN.
- RUN: one bit per cycle.
  - Multiply: shift-add over 2W-bit accumulator.
  - Divide: restoring shift-subtract.
  - count increments each cycle; → FIX when count==W-1.
- FIX: apply sign correction, write HI/LO/div_by_zero, pulse done, → IDLE.
  - Signed multiply: 2W-bit two's-complement product.
  - Signed divide: quotient truncates toward zero; remainder takes the dividend's sign.
  - Overflow case -2^(W-1)/-1: LO=-2^(W-1), HI=0 (natural wrap, no flag).
- busy = (state != IDLE). start while busy is ignored.
- hi/lo/div_by_zero hold their values between completions. They change only at FIX exit or reset.
- flush=1: next edge forces IDLE; HI/LO/div_by_zero unchanged; no done pulse. If start and flush are asserted in the same cycle, flush wins and start is dropped.
- Reset asserted mid-operation: immediate return to reset values; the partial result is discarded.

## Timing
- Start accepted in cycle c0.
  - PREP occupies c1.
  - RUN occupies c2..c(W+1).
  - FIX occupies c(W+2).
  - done=1 with new hi/lo in c(W+3).
- Latency is W+3 cycles (35 for W=32).
- Divide by zero: FIX in c1, done in c2.
- busy is high from c1 through the FIX cycle inclusive, and low in the done cycle. A new start is accepted in the done cycle itself.
- Back-to-back throughput: one operation per W+3 cycles.

## Configuration
- MULDIV_EARLY_OUT_EN defined: multiply RUN exits to FIX once the remaining (post-shift) multiplier bits are all zero. RUN then lasts max(1, bitlen(|B|)) cycles, and latency is 3+that.
  - Divide timing is unchanged.
  - Results are bit-identical to the undefined case.
- Undefined: fixed W-cycle RUN for all ops (deterministic latency).

## Test plan
- Reset and MULT: reset low mid-RUN → all outputs 0 immediately. Then MULT 7 × -3 (W=32) → done 35 cycles after start, HI=0xFFFFFFFF, LO=0xFFFFFFEB.
- Divides:
  - DIVU 100 / 7 → LO=14, HI=2, div_by_zero=0.
  - DIV -7 / 2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF.
  - DIV 0x80000000 / -1 → LO=0x80000000, HI=0.
- Divide by zero: DIV 5 / 0 → done 2 cycles after start, HI=5, LO=0xFFFFFFFF, div_by_zero=1. A following MULTU 2×3 → HI=0, LO=6, div_by_zero=0.
- Busy handshake:
  - start pulsed again while busy → ignored, single done, result of the first op.
  - start held high in the done cycle → second op accepted; busy high again next cycle.
- Flush:
  - flush at c10 of MULT → busy low at c11, no done, HI/LO keep prior values.
  - start and flush in the same cycle → no launch.
- MULDIV_EARLY_OUT_EN: MULTU 0x1234 × 5 → done 6 cycles after start, LO=0x5B04. MULTU × 0 → done 4 cycles after start, HI=LO=0. Macro undefined → both ops take 35 cycles.
